// File: rtl/pet_status_tracker.sv
// pet_status_tracker
// Game-logic stage that feeds the display control FSM. Keeps the pet's
// hunger, boredom and dirt meters, an idle counter and a health state
// machine, all advanced by a 1 Hz game tick and the item-given pulses.
//
// Ports
//   clk, reset           system clock, synchronous active-high reset
//   game_run             high while the game screen is active; low holds all state
//   sec_tick             1-cycle pulse once per game second
//   food_given .. first_aid_given   1-cycle item pulses
//   hunger/bored/dirty/sick/dying/zzzs_enable   registered bubble-select flags
//   dead                 sticky game-over flag
//   hunger/bored/dirt_level          current meter values
module pet_status_tracker #(
  parameter int LVL_W         = 3,
  parameter int THRESH        = 4,
  parameter int HUNGER_PERIOD = 30,
  parameter int BORED_PERIOD  = 20,
  parameter int DIRT_PERIOD   = 45,
  parameter int FEED_AMT      = 3,
  parameter int PLAY_AMT      = 3,
  parameter int SICK_SECS     = 10,
  parameter int DYING_SECS    = 20,
  parameter int DEATH_SECS    = 20,
  parameter int IDLE_SECS     = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             game_run,
  input  logic             sec_tick,
  input  logic             food_given,
  input  logic             ball_given,
  input  logic             broom_given,
  input  logic             pills_given,
  input  logic             first_aid_given,
  output logic             hunger_enable,
  output logic             bored_enable,
  output logic             dirty_enable,
  output logic             sick_enable,
  output logic             dying_enable,
  output logic             zzzs_enable,
  output logic             dead,
  output logic [LVL_W-1:0] hunger_level,
  output logic [LVL_W-1:0] bored_level,
  output logic [LVL_W-1:0] dirt_level
);

  typedef enum logic [1:0] {HEALTHY, SICK, DYING, DEAD} health_t;

  localparam logic [LVL_W-1:0] MAX_LEVEL   = '1;
  localparam logic [7:0]       H_LAST      = 8'(HUNGER_PERIOD - 1);
  localparam logic [7:0]       B_LAST      = 8'(BORED_PERIOD - 1);
  localparam logic [7:0]       D_LAST      = 8'(DIRT_PERIOD - 1);
  localparam logic [7:0]       SICK_LAST   = 8'(SICK_SECS - 1);
  localparam logic [7:0]       DYING_LAST  = 8'(DYING_SECS - 1);
  localparam logic [7:0]       DEATH_LAST  = 8'(DEATH_SECS - 1);
  localparam logic [7:0]       IDLE_LIMIT  = 8'(IDLE_SECS);

  function automatic logic [LVL_W-1:0] sat_inc(input logic [LVL_W-1:0] v);
    return (v == MAX_LEVEL) ? v : v + 1'b1;
  endfunction

  function automatic logic [LVL_W-1:0] sat_sub(input logic [LVL_W-1:0] v, input int amt);
    return (int'(v) > amt) ? v - LVL_W'(amt) : '0;
  endfunction

  function automatic logic at_thresh(input logic [LVL_W-1:0] v);
    return int'(v) >= THRESH;
  endfunction

  health_t          health, health_nxt;
  logic [7:0]       state_timer, state_timer_nxt;
  logic [7:0]       idle_cnt, idle_cnt_nxt;
  logic [7:0]       hunger_cnt, hunger_cnt_nxt;
  logic [7:0]       bored_cnt, bored_cnt_nxt;
  logic [7:0]       dirt_cnt, dirt_cnt_nxt;
  logic [LVL_W-1:0] hunger_nxt, bored_nxt, dirt_nxt;
  logic             tick, live, any_item;

  // live: game running and pet not dead, so meters and items are honoured
  assign tick     = game_run & sec_tick;
  assign live     = game_run & (health != DEAD);
  assign any_item = food_given | ball_given | broom_given | pills_given | first_aid_given;

  // Meters: an item on a meter overrides a coincident tick step
  always_comb begin
    hunger_nxt     = hunger_level;
    hunger_cnt_nxt = hunger_cnt;
    bored_nxt      = bored_level;
    bored_cnt_nxt  = bored_cnt;
    dirt_nxt       = dirt_level;
    dirt_cnt_nxt   = dirt_cnt;
    idle_cnt_nxt   = idle_cnt;
    if (live) begin
      if (food_given) begin
        hunger_nxt     = sat_sub(hunger_level, FEED_AMT);
        hunger_cnt_nxt = '0;
      end else if (sec_tick) begin
        if (hunger_cnt == H_LAST) begin
          hunger_cnt_nxt = '0;
          hunger_nxt     = sat_inc(hunger_level);
        end else begin
          hunger_cnt_nxt = hunger_cnt + 8'd1;
        end
      end

      if (ball_given) begin
        bored_nxt     = sat_sub(bored_level, PLAY_AMT);
        bored_cnt_nxt = '0;
      end else if (sec_tick) begin
        if (bored_cnt == B_LAST) begin
          bored_cnt_nxt = '0;
          bored_nxt     = sat_inc(bored_level);
        end else begin
          bored_cnt_nxt = bored_cnt + 8'd1;
        end
      end

      if (broom_given) begin
        dirt_nxt     = '0;
        dirt_cnt_nxt = '0;
      end else if (sec_tick) begin
        if (dirt_cnt == D_LAST) begin
          dirt_cnt_nxt = '0;
          dirt_nxt     = sat_inc(dirt_level);
        end else begin
          dirt_cnt_nxt = dirt_cnt + 8'd1;
        end
      end

      if (any_item)
        idle_cnt_nxt = '0;
      else if (sec_tick && idle_cnt != 8'hFF)
        idle_cnt_nxt = idle_cnt + 8'd1;
    end
  end

  // Health: the state timer restarts on every transition; a rescue pulse
  // beats a timeout landing in the same cycle
  always_comb begin
    health_nxt      = health;
    state_timer_nxt = state_timer;
    if (game_run) begin
      unique case (health)
        HEALTHY: begin
          if (hunger_level == MAX_LEVEL || dirt_level == MAX_LEVEL) begin
            if (tick) begin
              if (state_timer == SICK_LAST) begin
                health_nxt      = SICK;
                state_timer_nxt = '0;
              end else begin
                state_timer_nxt = state_timer + 8'd1;
              end
            end
          end else begin
            state_timer_nxt = '0;
          end
        end
        SICK: begin
          if (pills_given) begin
            health_nxt      = HEALTHY;
            state_timer_nxt = '0;
          end else if (tick) begin
            if (state_timer == DYING_LAST) begin
              health_nxt      = DYING;
              state_timer_nxt = '0;
            end else begin
              state_timer_nxt = state_timer + 8'd1;
            end
          end
        end
        DYING: begin
          if (first_aid_given) begin
            health_nxt      = SICK;
            state_timer_nxt = '0;
          end else if (tick) begin
            if (state_timer == DEATH_LAST) begin
              health_nxt      = DEAD;
              state_timer_nxt = '0;
            end else begin
              state_timer_nxt = state_timer + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Flags are registered from next-state values so they follow the
  // causing pulse/tick by exactly one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      health        <= HEALTHY;
      state_timer   <= '0;
      idle_cnt      <= '0;
      hunger_cnt    <= '0;
      bored_cnt     <= '0;
      dirt_cnt      <= '0;
      hunger_level  <= '0;
      bored_level   <= '0;
      dirt_level    <= '0;
      hunger_enable <= 1'b0;
      bored_enable  <= 1'b0;
      dirty_enable  <= 1'b0;
      sick_enable   <= 1'b0;
      dying_enable  <= 1'b0;
      zzzs_enable   <= 1'b0;
      dead          <= 1'b0;
    end else begin
      health        <= health_nxt;
      state_timer   <= state_timer_nxt;
      idle_cnt      <= idle_cnt_nxt;
      hunger_cnt    <= hunger_cnt_nxt;
      bored_cnt     <= bored_cnt_nxt;
      dirt_cnt      <= dirt_cnt_nxt;
      hunger_level  <= hunger_nxt;
      bored_level   <= bored_nxt;
      dirt_level    <= dirt_nxt;
      dead          <= (health_nxt == DEAD);
      hunger_enable <= (health_nxt != DEAD) && at_thresh(hunger_nxt);
      bored_enable  <= (health_nxt != DEAD) && at_thresh(bored_nxt);
      dirty_enable  <= (health_nxt != DEAD) && at_thresh(dirt_nxt);
      sick_enable   <= (health_nxt == SICK);
      dying_enable  <= (health_nxt == DYING);
      zzzs_enable   <= (health_nxt == HEALTHY) && !at_thresh(hunger_nxt) &&
                       !at_thresh(bored_nxt) && !at_thresh(dirt_nxt) &&
                       (idle_cnt_nxt >= IDLE_LIMIT);
    end
  end

endmodule

// File: tb/tb_pet_status_tracker.sv
module tb_pet_status_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, game_run, sec_tick;
  logic food_given, ball_given, broom_given, pills_given, first_aid_given;
  logic hunger_enable, bored_enable, dirty_enable, sick_enable, dying_enable, zzzs_enable, dead;
  logic [2:0] hunger_level, bored_level, dirt_level;

  pet_status_tracker dut (
    .clk(clk), .reset(reset), .game_run(game_run), .sec_tick(sec_tick),
    .food_given(food_given), .ball_given(ball_given), .broom_given(broom_given),
    .pills_given(pills_given), .first_aid_given(first_aid_given),
    .hunger_enable(hunger_enable), .bored_enable(bored_enable), .dirty_enable(dirty_enable),
    .sick_enable(sick_enable), .dying_enable(dying_enable), .zzzs_enable(zzzs_enable),
    .dead(dead), .hunger_level(hunger_level), .bored_level(bored_level), .dirt_level(dirt_level)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: seconds elapsed per meter, health as a small integer
  // (0 healthy, 1 sick, 2 dying, 3 dead)
  int m_h, m_b, m_d, m_hs, m_bs, m_ds, m_health, m_secs, m_idle;

  function automatic int imin(input int a, input int b); return (a < b) ? a : b; endfunction
  function automatic int imax(input int a, input int b); return (a > b) ? a : b; endfunction

  task automatic model_step();
    int h0, d0;
    bit tk, items;
    if (reset) begin
      m_h = 0; m_b = 0; m_d = 0; m_hs = 0; m_bs = 0; m_ds = 0;
      m_health = 0; m_secs = 0; m_idle = 0;
      return;
    end
    if (!game_run) return;
    h0 = m_h; d0 = m_d; tk = sec_tick;
    items = food_given | ball_given | broom_given | pills_given | first_aid_given;
    if (m_health != 3) begin
      if (food_given) begin m_h = imax(m_h - 3, 0); m_hs = 0; end
      else if (tk) begin m_hs++; if (m_hs == 30) begin m_hs = 0; m_h = imin(m_h + 1, 7); end end
      if (ball_given) begin m_b = imax(m_b - 3, 0); m_bs = 0; end
      else if (tk) begin m_bs++; if (m_bs == 20) begin m_bs = 0; m_b = imin(m_b + 1, 7); end end
      if (broom_given) begin m_d = 0; m_ds = 0; end
      else if (tk) begin m_ds++; if (m_ds == 45) begin m_ds = 0; m_d = imin(m_d + 1, 7); end end
      if (items) m_idle = 0;
      else if (tk) m_idle = imin(m_idle + 1, 255);
    end
    case (m_health)
      0: if (h0 == 7 || d0 == 7) begin
           if (tk) begin m_secs++; if (m_secs >= 10) begin m_health = 1; m_secs = 0; end end
         end else m_secs = 0;
      1: if (pills_given) begin m_health = 0; m_secs = 0; end
         else if (tk) begin m_secs++; if (m_secs >= 20) begin m_health = 2; m_secs = 0; end end
      2: if (first_aid_given) begin m_health = 1; m_secs = 0; end
         else if (tk) begin m_secs++; if (m_secs >= 20) begin m_health = 3; m_secs = 0; end end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    bit alive;
    alive = (m_health != 3);
    check_eq("hunger_level", hunger_level, m_h);
    check_eq("bored_level", bored_level, m_b);
    check_eq("dirt_level", dirt_level, m_d);
    check_eq("dead", dead, !alive);
    check_eq("hunger_enable", hunger_enable, alive && m_h >= 4);
    check_eq("bored_enable", bored_enable, alive && m_b >= 4);
    check_eq("dirty_enable", dirty_enable, alive && m_d >= 4);
    check_eq("sick_enable", sick_enable, m_health == 1);
    check_eq("dying_enable", dying_enable, m_health == 2);
    check_eq("zzzs_enable", zzzs_enable,
             m_health == 0 && m_h < 4 && m_b < 4 && m_d < 4 && m_idle >= 15);
  endtask

  task automatic cycle(input bit r, input bit run, input bit tk, input bit f, input bit b,
                       input bit br, input bit p, input bit fa);
    @(negedge clk);
    reset = r; game_run = run; sec_tick = tk;
    food_given = f; ball_given = b; broom_given = br; pills_given = p; first_aid_given = fa;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic bit pr(input int n);
    return $urandom_range(n - 1) == 0;
  endfunction

  task automatic random_phase(input int cycles, input int item_n, input int rescue_n,
                              input int run_off_n, input int reset_n);
    for (int i = 0; i < cycles; i++)
      cycle(pr(reset_n), !pr(run_off_n), pr(2), pr(item_n), pr(item_n), pr(item_n * 3),
            pr(rescue_n), pr(rescue_n));
  endtask

  initial begin
    reset = 1'b1; game_run = 1'b0; sec_tick = 1'b0;
    food_given = 1'b0; ball_given = 1'b0; broom_given = 1'b0;
    pills_given = 1'b0; first_aid_given = 1'b0;
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 0, 0, 0, 0);
    check_eq("reset_hunger", hunger_level, 0);
    check_eq("reset_dead", dead, 0);

    // 120 ticks from reset
    for (int i = 0; i < 120; i++) begin
      cycle(0, 1, 1, 0, 0, 0, 0, 0);
      if (i < 119) cycle(0, 1, 0, 0, 0, 0, 0, 0);
    end
    check_eq("t1_hunger", hunger_level, 4);
    check_eq("t1_hunger_en", hunger_enable, 1);
    check_eq("t1_bored", bored_level, 6);
    check_eq("t1_dirt", dirt_level, 2);

    // Let hunger saturate and the pet die untended
    for (int i = 0; i < 160; i++) cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check_eq("t4_dead", dead, 1);
    check_eq("t4_sick_en", sick_enable, 0);
    cycle(0, 1, 0, 1, 1, 1, 1, 1);
    check_eq("t4_food_ignored", hunger_level, 7);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    check_eq("t4_reset_dead", dead, 0);
    check_eq("t4_reset_hunger", hunger_level, 0);

    // Idle bubble
    for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0, 0, 0, 0, 0);
    check_eq("t5_zzzs", zzzs_enable, 1);
    cycle(0, 1, 0, 0, 1, 0, 0, 0);
    check_eq("t5_zzzs_clear", zzzs_enable, 0);

    // Frozen while game_run is low
    for (int i = 0; i < 100; i++)
      cycle(0, 0, 1, pr(4), pr(4), pr(4), pr(4), pr(4));

    // Randomized play: sparse items, then rescue-heavy, with occasional resets
    random_phase(3000, 60, 200, 10, 2000);
    random_phase(3000, 150, 25, 10, 1500);
    random_phase(1500, 20, 8, 4, 800);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
